// File: rtl/game_fsm.sv
// game_fsm: central sequencer for the 4-digit 1A2B guessing game.
// Decodes the switches, gates confirm presses, holds target/guess digits,
// scores each guess, counts remaining chances and runs the blink enable.

package game_types;
  typedef enum logic [3:0] {
    S_IDLE        = 4'd0,
    S_SET_D3      = 4'd1,
    S_SET_D2      = 4'd2,
    S_SET_D1      = 4'd3,
    S_SET_D0      = 4'd4,
    S_GUESS_D3    = 4'd5,
    S_GUESS_D2    = 4'd6,
    S_GUESS_D1    = 4'd7,
    S_GUESS_D0    = 4'd8,
    S_SHOW_RESULT = 4'd9,
    S_WIN         = 4'd10,
    S_LOSE        = 4'd11
  } state_t;
endpackage

module game_fsm
  import game_types::*;
#(
  parameter int BLINK_HALF  = 25_000_000,
  parameter int MAX_CHANCES = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [9:0]      sw,
  input  logic            btn_confirm,
  output state_t          state,
  output logic            blink_on,
  output logic [3:0][3:0] target,
  output logic [3:0][3:0] guess,
  output logic [3:0]      candidate,
  output logic            sw_valid,
  output logic [2:0]      chances,
  output logic [2:0]      a_count,
  output logic [2:0]      b_count
);

  localparam int CNT_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_HALF - 1);
  localparam logic [2:0] CHANCES_INIT = 3'(MAX_CHANCES);

  logic [CNT_W-1:0] blink_cnt;
  state_t           next_state;

  // digit-entry qualification
  logic             digit_state;
  logic             set_state;
  logic [1:0]       dig_idx;
  logic [3:0][3:0]  entry_digits;
  logic             accept;

  // scoring of {guess[3:1], candidate}
  logic [3:0][3:0]  eval_digits;
  logic [2:0]       a_eval;
  logic [2:0]       b_eval;

  // datapath strobes from the output decoder
  logic             start_round;
  logic             wr_target;
  logic             wr_guess;
  logic             clr_guess;
  logic             clr_all;
  logic             eval_ld;
  logic             dec_chances;

  // Index of the single high switch; caller guarantees one-hot input.
  function automatic logic [3:0] onehot_index(input logic [9:0] s);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (s[i]) idx = 4'(i);
    end
    return idx;
  endfunction

  // True when c repeats a digit already entered above position idx.
  function automatic logic is_dup(input logic [3:0][3:0] d,
                                  input logic [3:0]      c,
                                  input logic [1:0]      idx);
    logic hit;
    hit = 1'b0;
    for (int i = 1; i < 4; i++) begin
      if ((i > int'(idx)) && (d[i] == c)) hit = 1'b1;
    end
    return hit;
  endfunction

  // Count of positional matches between target and guess.
  function automatic logic [2:0] count_a(input logic [3:0][3:0] t,
                                         input logic [3:0][3:0] g);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < 4; i++) begin
      if (t[i] == g[i]) n = n + 3'd1;
    end
    return n;
  endfunction

  // Count of guess digits found in the target at some other position.
  function automatic logic [2:0] count_b(input logic [3:0][3:0] t,
                                         input logic [3:0][3:0] g);
    logic [2:0] n;
    logic       hit;
    n = 3'd0;
    for (int i = 0; i < 4; i++) begin
      hit = 1'b0;
      for (int j = 0; j < 4; j++) begin
        if ((i != j) && (g[i] == t[j])) hit = 1'b1;
      end
      if (hit) n = n + 3'd1;
    end
    return n;
  endfunction

  // Free-running blink divider; independent of the game state.
  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt <= '0;
      blink_on  <= 1'b0;
    end else if (blink_cnt == CNT_LAST) begin
      blink_cnt <= '0;
      blink_on  <= ~blink_on;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  // Registered switch decode: one-hot gives a digit, anything else is invalid.
  always_ff @(posedge clk) begin
    if (rst) begin
      candidate <= 4'd0;
      sw_valid  <= 1'b0;
    end else if ($onehot(sw)) begin
      candidate <= onehot_index(sw);
      sw_valid  <= 1'b1;
    end else begin
      candidate <= 4'd0;
      sw_valid  <= 1'b0;
    end
  end

  // Decide whether a confirm press in a digit-entry state is accepted.
  always_comb begin
    digit_state  = 1'b0;
    set_state    = 1'b0;
    dig_idx      = 2'd3;
    entry_digits = target;
    case (state)
      S_SET_D3:   begin digit_state = 1'b1; set_state = 1'b1; dig_idx = 2'd3; end
      S_SET_D2:   begin digit_state = 1'b1; set_state = 1'b1; dig_idx = 2'd2; end
      S_SET_D1:   begin digit_state = 1'b1; set_state = 1'b1; dig_idx = 2'd1; end
      S_SET_D0:   begin digit_state = 1'b1; set_state = 1'b1; dig_idx = 2'd0; end
      S_GUESS_D3: begin digit_state = 1'b1; dig_idx = 2'd3; entry_digits = guess; end
      S_GUESS_D2: begin digit_state = 1'b1; dig_idx = 2'd2; entry_digits = guess; end
      S_GUESS_D1: begin digit_state = 1'b1; dig_idx = 2'd1; entry_digits = guess; end
      S_GUESS_D0: begin digit_state = 1'b1; dig_idx = 2'd0; entry_digits = guess; end
      default:    begin digit_state = 1'b0; end
    endcase
    accept = digit_state && btn_confirm && sw_valid &&
             !is_dup(entry_digits, candidate, dig_idx);
  end

  // Score the guess with the last digit taken straight from the switch decode.
  always_comb begin
    eval_digits    = guess;
    eval_digits[0] = candidate;
    a_eval         = count_a(target, eval_digits);
    b_eval         = count_b(target, eval_digits);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  // Next-state logic; unknown encodings fall back to idle.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:        if (btn_confirm) next_state = S_SET_D3;
      S_SET_D3:      if (accept) next_state = S_SET_D2;
      S_SET_D2:      if (accept) next_state = S_SET_D1;
      S_SET_D1:      if (accept) next_state = S_SET_D0;
      S_SET_D0:      if (accept) next_state = S_GUESS_D3;
      S_GUESS_D3:    if (accept) next_state = S_GUESS_D2;
      S_GUESS_D2:    if (accept) next_state = S_GUESS_D1;
      S_GUESS_D1:    if (accept) next_state = S_GUESS_D0;
      S_GUESS_D0:    if (accept) next_state = (a_eval == 3'd4) ? S_WIN : S_SHOW_RESULT;
      S_SHOW_RESULT: if (btn_confirm) next_state = (chances == 3'd0) ? S_LOSE : S_GUESS_D3;
      S_WIN:         if (btn_confirm) next_state = S_IDLE;
      S_LOSE:        if (btn_confirm) next_state = S_IDLE;
      default:       next_state = S_IDLE;
    endcase
  end

  // Output decode: datapath strobes for the current state and inputs.
  always_comb begin
    start_round = (state == S_IDLE) && btn_confirm;
    wr_target   = accept && set_state;
    wr_guess    = accept && !set_state;
    eval_ld     = accept && (state == S_GUESS_D0);
    dec_chances = eval_ld && (a_eval != 3'd4);
    clr_guess   = (accept && (state == S_SET_D0)) ||
                  ((state == S_SHOW_RESULT) && btn_confirm && (chances != 3'd0));
    clr_all     = ((state == S_WIN) || (state == S_LOSE)) && btn_confirm;
  end

  // Digit, chance and score registers driven by the strobes above.
  always_ff @(posedge clk) begin
    if (rst) begin
      target  <= '0;
      guess   <= '0;
      chances <= CHANCES_INIT;
      a_count <= 3'd0;
      b_count <= 3'd0;
    end else begin
      if (start_round) begin
        chances <= CHANCES_INIT;
        a_count <= 3'd0;
        b_count <= 3'd0;
      end
      if (wr_target) target[dig_idx] <= candidate;
      if (wr_guess)  guess[dig_idx]  <= candidate;
      if (clr_guess) guess <= '0;
      if (eval_ld) begin
        a_count <= a_eval;
        b_count <= b_eval;
        if (dec_chances && (chances != 3'd0)) chances <= chances - 3'd1;
      end
      if (clr_all) begin
        target <= '0;
        guess  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_game_fsm.sv
// tb_game_fsm: table-driven directed bench for game_fsm with
// hand-written sequences for the lose path and a mid-game reset.

module tb_game_fsm;
  import game_types::*;

  logic            clk = 1'b0;
  logic            rst;
  logic [9:0]      sw;
  logic            btn_confirm;
  state_t          state;
  logic            blink_on;
  logic [3:0][3:0] target;
  logic [3:0][3:0] guess;
  logic [3:0]      candidate;
  logic            sw_valid;
  logic [2:0]      chances;
  logic [2:0]      a_count;
  logic [2:0]      b_count;

  int total = 0;
  int bad   = 0;

  game_fsm #(.BLINK_HALF(4), .MAX_CHANCES(5)) dut (
    .clk(clk), .rst(rst), .sw(sw), .btn_confirm(btn_confirm),
    .state(state), .blink_on(blink_on), .target(target), .guess(guess),
    .candidate(candidate), .sw_valid(sw_valid), .chances(chances),
    .a_count(a_count), .b_count(b_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0]  sw;
    logic        btn;
    state_t      st;
    logic [2:0]  ch;
    logic [2:0]  a;
    logic [2:0]  b;
    logic [15:0] tgt;
    logic [15:0] gs;
  } vec_t;

  vec_t tbl[33];

  function automatic logic [9:0] oh(input int k);
    return 10'd1 << k;
  endfunction

  function automatic vec_t mk(input logic [9:0] s, input logic b, input state_t st,
                              input int ch, input int a, input int bb,
                              input logic [15:0] t, input logic [15:0] g);
    vec_t v;
    v.sw = s; v.btn = b; v.st = st;
    v.ch = 3'(ch); v.a = 3'(a); v.b = 3'(bb);
    v.tgt = t; v.gs = g;
    return v;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Set switches to digit d, let decode register, then pulse confirm.
  task automatic press(input int d);
    sw = oh(d);
    btn_confirm = 1'b0;
    @(negedge clk);
    btn_confirm = 1'b1;
    @(negedge clk);
    btn_confirm = 1'b0;
  endtask

  task automatic press_btn();
    btn_confirm = 1'b1;
    @(negedge clk);
    btn_confirm = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] T;
    logic        exp_blink;
    logic        exp_valid;
    logic [3:0]  exp_cand;
    T = 16'h1234;

    tbl[0]  = mk(10'd0,         1, S_SET_D3,      5, 0, 0, 16'h0000, 16'h0000);
    tbl[1]  = mk(oh(5),         0, S_SET_D3,      5, 0, 0, 16'h0000, 16'h0000);
    tbl[2]  = mk(oh(5) | oh(0), 0, S_SET_D3,      5, 0, 0, 16'h0000, 16'h0000);
    tbl[3]  = mk(10'd0,         1, S_SET_D3,      5, 0, 0, 16'h0000, 16'h0000);
    tbl[4]  = mk(oh(1),         0, S_SET_D3,      5, 0, 0, 16'h0000, 16'h0000);
    tbl[5]  = mk(oh(1),         1, S_SET_D2,      5, 0, 0, 16'h1000, 16'h0000);
    tbl[6]  = mk(oh(1),         1, S_SET_D2,      5, 0, 0, 16'h1000, 16'h0000);
    tbl[7]  = mk(oh(2),         0, S_SET_D2,      5, 0, 0, 16'h1000, 16'h0000);
    tbl[8]  = mk(oh(2),         1, S_SET_D1,      5, 0, 0, 16'h1200, 16'h0000);
    tbl[9]  = mk(oh(3),         0, S_SET_D1,      5, 0, 0, 16'h1200, 16'h0000);
    tbl[10] = mk(oh(3),         1, S_SET_D0,      5, 0, 0, 16'h1230, 16'h0000);
    tbl[11] = mk(oh(4),         0, S_SET_D0,      5, 0, 0, 16'h1230, 16'h0000);
    tbl[12] = mk(oh(4),         1, S_GUESS_D3,    5, 0, 0, T,        16'h0000);
    tbl[13] = mk(oh(1),         0, S_GUESS_D3,    5, 0, 0, T,        16'h0000);
    tbl[14] = mk(oh(1),         1, S_GUESS_D2,    5, 0, 0, T,        16'h1000);
    tbl[15] = mk(oh(1),         1, S_GUESS_D2,    5, 0, 0, T,        16'h1000);
    tbl[16] = mk(oh(2),         0, S_GUESS_D2,    5, 0, 0, T,        16'h1000);
    tbl[17] = mk(oh(2),         1, S_GUESS_D1,    5, 0, 0, T,        16'h1200);
    tbl[18] = mk(oh(4),         0, S_GUESS_D1,    5, 0, 0, T,        16'h1200);
    tbl[19] = mk(oh(4),         1, S_GUESS_D0,    5, 0, 0, T,        16'h1240);
    tbl[20] = mk(oh(3),         0, S_GUESS_D0,    5, 0, 0, T,        16'h1240);
    tbl[21] = mk(oh(3),         1, S_SHOW_RESULT, 4, 2, 2, T,        16'h1243);
    tbl[22] = mk(oh(3),         1, S_GUESS_D3,    4, 2, 2, T,        16'h0000);
    tbl[23] = mk(oh(1),         0, S_GUESS_D3,    4, 2, 2, T,        16'h0000);
    tbl[24] = mk(oh(1),         1, S_GUESS_D2,    4, 2, 2, T,        16'h1000);
    tbl[25] = mk(oh(2),         0, S_GUESS_D2,    4, 2, 2, T,        16'h1000);
    tbl[26] = mk(oh(2),         1, S_GUESS_D1,    4, 2, 2, T,        16'h1200);
    tbl[27] = mk(oh(3),         0, S_GUESS_D1,    4, 2, 2, T,        16'h1200);
    tbl[28] = mk(oh(3),         1, S_GUESS_D0,    4, 2, 2, T,        16'h1230);
    tbl[29] = mk(oh(4),         0, S_GUESS_D0,    4, 2, 2, T,        16'h1230);
    tbl[30] = mk(oh(4),         1, S_WIN,         4, 4, 0, T,        16'h1234);
    tbl[31] = mk(oh(4),         1, S_IDLE,        4, 4, 0, 16'h0000, 16'h0000);
    tbl[32] = mk(oh(4),         1, S_SET_D3,      5, 0, 0, 16'h0000, 16'h0000);

    // reset and blink
    rst = 1'b1;
    sw = 10'd0;
    btn_confirm = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_state", 16'(state), 16'(S_IDLE));
    chk("reset_chances", 16'(chances), 16'd5);
    chk("reset_blink", 16'(blink_on), 16'd0);
    chk("reset_ab", {10'd0, a_count, b_count}, 16'd0);
    rst = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      exp_blink = (i >= 4) && (i <= 7);
      chk($sformatf("blink_cyc%0d", i), 16'(blink_on), 16'(exp_blink));
    end

    // table-driven vectors
    for (int i = 0; i < 33; i++) begin
      sw = tbl[i].sw;
      btn_confirm = tbl[i].btn;
      @(negedge clk);
      exp_valid = $onehot(tbl[i].sw);
      exp_cand  = exp_valid ? 4'($clog2(tbl[i].sw)) : 4'd0;
      chk($sformatf("row%0d_state", i), 16'(state), 16'(tbl[i].st));
      chk($sformatf("row%0d_chances", i), 16'(chances), 16'(tbl[i].ch));
      chk($sformatf("row%0d_a", i), 16'(a_count), 16'(tbl[i].a));
      chk($sformatf("row%0d_b", i), 16'(b_count), 16'(tbl[i].b));
      chk($sformatf("row%0d_target", i), target, tbl[i].tgt);
      chk($sformatf("row%0d_guess", i), guess, tbl[i].gs);
      chk($sformatf("row%0d_valid", i), 16'(sw_valid), 16'(exp_valid));
      chk($sformatf("row%0d_cand", i), 16'(candidate), 16'(exp_cand));
    end
    btn_confirm = 1'b0;

    // lose path: five wrong guesses of 5678 against 1234
    press(1); press(2); press(3); press(4);
    chk("lose_setup_state", 16'(state), 16'(S_GUESS_D3));
    chk("lose_setup_target", target, 16'h1234);
    for (int k = 1; k <= 5; k++) begin
      press(5); press(6); press(7); press(8);
      chk($sformatf("lose_g%0d_state", k), 16'(state), 16'(S_SHOW_RESULT));
      chk($sformatf("lose_g%0d_chances", k), 16'(chances), 16'(5 - k));
      chk($sformatf("lose_g%0d_ab", k), {10'd0, a_count, b_count}, 16'd0);
      chk($sformatf("lose_g%0d_guess", k), guess, 16'h5678);
      if (k < 5) begin
        press_btn();
        chk($sformatf("lose_g%0d_next", k), 16'(state), 16'(S_GUESS_D3));
      end
    end
    press_btn();
    chk("lose_state", 16'(state), 16'(S_LOSE));
    chk("lose_target_kept", target, 16'h1234);
    chk("lose_chances", 16'(chances), 16'd0);
    press_btn();
    chk("lose_to_idle", 16'(state), 16'(S_IDLE));
    chk("lose_target_clr", target, 16'h0000);
    chk("lose_guess_clr", guess, 16'h0000);

    // mid-game reset from GUESS_D1
    press_btn();
    chk("mid_round_start", 16'(state), 16'(S_SET_D3));
    chk("mid_chances_reload", 16'(chances), 16'd5);
    press(1); press(2); press(3); press(4);
    press(5); press(6);
    chk("mid_pre_state", 16'(state), 16'(S_GUESS_D1));
    chk("mid_pre_guess", guess, 16'h5600);
    rst = 1'b1;
    sw = 10'd0;
    @(negedge clk);
    chk("mid_rst_state", 16'(state), 16'(S_IDLE));
    chk("mid_rst_target", target, 16'h0000);
    chk("mid_rst_guess", guess, 16'h0000);
    chk("mid_rst_chances", 16'(chances), 16'd5);
    chk("mid_rst_ab", {10'd0, a_count, b_count}, 16'd0);
    chk("mid_rst_cand", {11'd0, sw_valid, candidate}, 16'd0);
    chk("mid_rst_blink", 16'(blink_on), 16'd0);
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
